// File: rtl/load_store_unit_pkg.sv
// Shared definitions for the load/store unit: funct3 codes, FSM states, fault causes.
// Includes the legality/alignment helpers used at request accept.
package load_store_unit_pkg;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    typedef enum logic [2:0] {
        IDLE,
        ST_ISSUE,
        RD_ISSUE,
        RD_SKIP,
        RD_WAIT
    } lsu_state_e;

    typedef enum logic [1:0] {
        CAUSE_NONE     = 2'b00,
        CAUSE_MISALIGN = 2'b01,
        CAUSE_FUNCT3   = 2'b10,
        CAUSE_TIMEOUT  = 2'b11
    } fault_cause_e;

    function automatic logic f3_legal(input logic store, input logic [2:0] f3);
        if (store) begin
            return (f3 == F3_SB) || (f3 == F3_SH) || (f3 == F3_SW);
        end
        return (f3 == F3_LB) || (f3 == F3_LH) || (f3 == F3_LW) ||
               (f3 == F3_LBU) || (f3 == F3_LHU);
    endfunction

    // Size is encoded in funct3[1:0] for both loads and stores.
    function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] offset);
        case (f3[1:0])
            2'b01:   return offset[0];
            2'b10:   return offset != 2'b00;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/load_store_unit_load_align.sv
// Combinational load formatter: picks the byte/half addressed by the offset and
// sign- or zero-extends it according to funct3.
module lsu_load_align
    import load_store_unit_pkg::*;
(
    input  logic [31:0] rdata_i,
    input  logic [1:0]  offset_i,
    input  logic [2:0]  funct3_i,
    output logic [31:0] result_o
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;

    always_comb begin
        byte_v = rdata_i[8*offset_i +: 8];
        half_v = offset_i[1] ? rdata_i[31:16] : rdata_i[15:0];
        case (funct3_i)
            F3_LB:   result_o = {{24{byte_v[7]}}, byte_v};
            F3_LH:   result_o = {{16{half_v[15]}}, half_v};
            F3_LBU:  result_o = 32'(byte_v);
            F3_LHU:  result_o = 32'(half_v);
            default: result_o = rdata_i;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: accepts one request, drives the memory data port handshake, formats loads.
// Optional read watchdog enabled by defining LSU_TIMEOUT_EN.
module load_store_unit
    import load_store_unit_pkg::*;
#(
    parameter int unsigned MEM_AW         = 10,
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_store,
    input  logic [2:0]        req_funct3,
    input  logic [31:0]       req_addr,
    input  logic [31:0]       req_wdata,
    output logic              done,
    output logic [31:0]       load_data,
    output logic              fault,
    output logic [1:0]        fault_cause,
    output logic [MEM_AW-1:0] data_addr,
    output logic              ren,
    output logic              wen,
    output logic [31:0]       mem_wdata,
    output logic [3:0]        byte_select_vector,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_ready
);

    lsu_state_e        state_q, state_d;
    logic [MEM_AW-1:0] addr_q, addr_d;
    logic [1:0]        off_q, off_d;
    logic [2:0]        f3_q, f3_d;
    logic              ren_q, ren_d, wen_q, wen_d;
    logic              done_q, done_d, fault_q, fault_d;
    fault_cause_e      cause_q, cause_d;
    logic [3:0]        be_q, be_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [31:0]       ldata_q, ldata_d;
    logic [31:0]       aligned;

    // Address bits above the memory word range are not routed anywhere.
    logic unused_addr_hi;
    assign unused_addr_hi = ^req_addr[31:MEM_AW+2];

`ifdef LSU_TIMEOUT_EN
    localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    logic [CNT_W-1:0] wd_q, wd_d;
`else
    localparam int unsigned UNUSED_TIMEOUT_CYCLES = TIMEOUT_CYCLES;
`endif

    lsu_load_align u_align (
        .rdata_i  (mem_rdata),
        .offset_i (off_q),
        .funct3_i (f3_q),
        .result_o (aligned)
    );

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        off_d   = off_q;
        f3_d    = f3_q;
        ren_d   = 1'b0;
        wen_d   = 1'b0;
        done_d  = 1'b0;
        fault_d = 1'b0;
        cause_d = CAUSE_NONE;
        be_d    = be_q;
        wdata_d = wdata_q;
        ldata_d = ldata_q;
`ifdef LSU_TIMEOUT_EN
        wd_d    = wd_q;
`endif
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    if (!f3_legal(req_store, req_funct3)) begin
                        fault_d = 1'b1;
                        cause_d = CAUSE_FUNCT3;
                    end else if (misaligned(req_funct3, req_addr[1:0])) begin
                        fault_d = 1'b1;
                        cause_d = CAUSE_MISALIGN;
                    end else begin
                        addr_d = req_addr[MEM_AW+1:2];
                        off_d  = req_addr[1:0];
                        f3_d   = req_funct3;
                        if (req_store) begin
                            state_d = ST_ISSUE;
                            wen_d   = 1'b1;
                            case (req_funct3[1:0])
                                2'b00: begin
                                    be_d    = 4'b0001 << req_addr[1:0];
                                    wdata_d = {4{req_wdata[7:0]}};
                                end
                                2'b01: begin
                                    be_d    = 4'b0011 << req_addr[1:0];
                                    wdata_d = {2{req_wdata[15:0]}};
                                end
                                default: begin
                                    be_d    = '1;
                                    wdata_d = req_wdata;
                                end
                            endcase
                        end else begin
                            state_d = RD_ISSUE;
                            ren_d   = 1'b1;
                        end
                    end
                end
            end
            ST_ISSUE: begin
                state_d = IDLE;
                done_d  = 1'b1;
            end
            RD_ISSUE: state_d = RD_SKIP;
            RD_SKIP: begin
                state_d = RD_WAIT;
`ifdef LSU_TIMEOUT_EN
                wd_d    = '0;
`endif
            end
            RD_WAIT: begin
                if (mem_ready) begin
                    ldata_d = aligned;
                    done_d  = 1'b1;
                    state_d = IDLE;
`ifdef LSU_TIMEOUT_EN
                end else if (wd_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    ldata_d = '0;
                    fault_d = 1'b1;
                    cause_d = CAUSE_TIMEOUT;
                    state_d = IDLE;
                end else begin
                    wd_d = wd_q + 1'b1;
`endif
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            addr_q  <= '0;
            off_q   <= '0;
            f3_q    <= '0;
            ren_q   <= 1'b0;
            wen_q   <= 1'b0;
            done_q  <= 1'b0;
            fault_q <= 1'b0;
            cause_q <= CAUSE_NONE;
            be_q    <= '0;
            wdata_q <= '0;
            ldata_q <= '0;
`ifdef LSU_TIMEOUT_EN
            wd_q    <= '0;
`endif
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            off_q   <= off_d;
            f3_q    <= f3_d;
            ren_q   <= ren_d;
            wen_q   <= wen_d;
            done_q  <= done_d;
            fault_q <= fault_d;
            cause_q <= cause_d;
            be_q    <= be_d;
            wdata_q <= wdata_d;
            ldata_q <= ldata_d;
`ifdef LSU_TIMEOUT_EN
            wd_q    <= wd_d;
`endif
        end
    end

    assign req_ready          = (state_q == IDLE);
    assign done               = done_q;
    assign load_data          = ldata_q;
    assign fault              = fault_q;
    assign fault_cause        = cause_q;
    assign data_addr          = addr_q;
    assign ren                = ren_q;
    assign wen                = wen_q;
    assign mem_wdata          = wdata_q;
    assign byte_select_vector = be_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: byte-level reference memory, directed plus random requests,
// stalled-read and asynchronous-reset scenarios.
module tb_load_store_unit;

    localparam int unsigned MEM_AW = 10;
    localparam int unsigned TO     = 16;
    localparam int unsigned LAT    = 6;

    logic              clk = 1'b0;
    logic              reset;
    logic              req_valid, req_ready, req_store;
    logic [2:0]        req_funct3;
    logic [31:0]       req_addr, req_wdata;
    logic              done, fault;
    logic [31:0]       load_data;
    logic [1:0]        fault_cause;
    logic [MEM_AW-1:0] data_addr;
    logic              ren, wen;
    logic [31:0]       mem_wdata, mem_rdata;
    logic [3:0]        byte_select_vector;
    logic              mem_ready;
    logic              stuck;

    int checks   = 0;
    int failures = 0;

    logic [7:0]  rb [0:4095];
    logic [31:0] mem [0:1023];
    int unsigned mcnt;

    always #5 clk = ~clk;

    load_store_unit #(.MEM_AW(MEM_AW), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .req_store(req_store), .req_funct3(req_funct3), .req_addr(req_addr),
        .req_wdata(req_wdata), .done(done), .load_data(load_data), .fault(fault),
        .fault_cause(fault_cause), .data_addr(data_addr), .ren(ren), .wen(wen),
        .mem_wdata(mem_wdata), .byte_select_vector(byte_select_vector),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready)
    );

    function automatic logic [31:0] init_word(input int unsigned i);
        return (i * 32'h9E3779B1) ^ 32'hC3A50F1E;
    endfunction

    // Memory: ready drops on a read strobe and returns LAT edges later with data.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_ready <= 1'b1;
            mem_rdata <= '0;
            mcnt      <= 0;
            for (int i = 0; i < 1024; i++) mem[i] <= init_word(i);
        end else begin
            if (wen)
                for (int i = 0; i < 4; i++)
                    if (byte_select_vector[i]) mem[data_addr][8*i +: 8] <= mem_wdata[8*i +: 8];
            if (ren) begin
                mem_ready <= 1'b0;
                mcnt      <= LAT;
            end else if (!mem_ready && !stuck) begin
                if (mcnt == 1) begin
                    mem_ready <= 1'b1;
                    mem_rdata <= mem[data_addr];
                end else begin
                    mcnt <= mcnt - 1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (!reset) begin
            checks++;
            assert (!(done && fault)) else begin
                failures++;
                $error("FAIL done_fault_overlap observed=%b%b expected=not_both", done, fault);
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic ref_init();
        for (int w = 0; w < 1024; w++) begin
            logic [31:0] word;
            word = init_word(w);
            for (int k = 0; k < 4; k++) rb[4*w+k] = word[8*k +: 8];
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic legal(input logic st, input logic [2:0] f3);
        return st ? (f3 inside {3'd0, 3'd1, 3'd2}) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    endfunction

    // Issues one request at posedge+1; returns at posedge+1 of the completion cycle (idle).
    task automatic run(input logic st, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd, input string tag);
        int unsigned sz, off;
        sz  = 1 << f3[1:0];
        off = a % 4;
        req_valid = 1'b1; req_store = st; req_funct3 = f3; req_addr = a; req_wdata = wd;
        step();
        req_valid = 1'b0;
        if (!legal(st, f3) || (a % sz) != 0) begin
            check({tag, "_fault"}, 32'(fault), 32'd1);
            check({tag, "_cause"}, 32'(fault_cause), legal(st, f3) ? 32'd1 : 32'd2);
            check({tag, "_nodone"}, 32'(done), 32'd0);
            check({tag, "_nobus"}, 32'(ren | wen), 32'd0);
            check({tag, "_ready"}, 32'(req_ready), 32'd1);
            step();
            check({tag, "_fault_end"}, 32'(fault), 32'd0);
            check({tag, "_nobus2"}, 32'(ren | wen), 32'd0);
        end else if (st) begin
            logic [3:0]  ebe;
            logic [31:0] ewd;
            ebe = '0;
            for (int i = 0; i < 4; i++) begin
                if (i >= off && i < off + sz) ebe[i] = 1'b1;
                ewd[8*i +: 8] = wd[8*(i % sz) +: 8];
            end
            check({tag, "_wen"}, 32'({wen, ren}), 32'b10);
            check({tag, "_addr"}, 32'(data_addr), 32'(a[11:2]));
            check({tag, "_be"}, 32'(byte_select_vector), 32'(ebe));
            check({tag, "_wdata"}, mem_wdata, ewd);
            check({tag, "_early_done"}, 32'(done), 32'd0);
            for (int i = 0; i < sz; i++) rb[a+i] = wd[8*i +: 8];
            step();
            check({tag, "_wen_end"}, 32'(wen), 32'd0);
            check({tag, "_done"}, 32'(done), 32'd1);
            check({tag, "_ready"}, 32'(req_ready), 32'd1);
        end else begin
            longint v, one;
            int done_k, ren_x, wen_x, flt_x;
            one = 1;
            v = 0;
            for (int i = 0; i < sz; i++) v += longint'(rb[a+i]) << (8*i);
            if (!f3[2] && sz < 4 && v >= (one << (8*sz-1))) v -= (one << (8*sz));
            check({tag, "_ren"}, 32'({ren, wen}), 32'b10);
            check({tag, "_addr"}, 32'(data_addr), 32'(a[11:2]));
            done_k = 0; ren_x = 0; wen_x = 0; flt_x = 0;
            for (int k = 1; k <= 300; k++) begin
                // Requests raised while busy must be ignored.
                req_valid = (k <= 2); req_store = 1'b1; req_funct3 = 3'b010; req_wdata = $urandom;
                step();
                if (ren) ren_x++;
                if (wen) wen_x++;
                if (fault) flt_x++;
                if (done) begin
                    done_k = k;
                    break;
                end
            end
            req_valid = 1'b0;
            check({tag, "_latency"}, 32'(done_k), 32'(LAT + 2));
            check({tag, "_data"}, load_data, v[31:0]);
            check({tag, "_ren_once"}, 32'(ren_x), 32'd0);
            check({tag, "_busy_ignored"}, 32'(wen_x), 32'd0);
            check({tag, "_nofault"}, 32'(flt_x), 32'd0);
            check({tag, "_ready"}, 32'(req_ready), 32'd1);
        end
    endtask

    task automatic async_reset(input string tag);
        #2 reset = 1'b1;
        #1;
        check({tag, "_ren"}, 32'(ren), 32'd0);
        check({tag, "_wen"}, 32'(wen), 32'd0);
        check({tag, "_done"}, 32'(done), 32'd0);
        check({tag, "_ready"}, 32'(req_ready), 32'd1);
        check({tag, "_addr"}, 32'(data_addr), 32'd0);
        stuck = 1'b0;
        ref_init();
        #1 reset = 1'b0;
        step();
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout observed=hung expected=finish");
        $fatal(1, "bench time limit");
    end

    initial begin
        int k, hits;
        reset = 1'b1; stuck = 1'b0;
        req_valid = 1'b0; req_store = 1'b0; req_funct3 = '0; req_addr = '0; req_wdata = '0;
        ref_init();
        #12;
        check("rst_ready", 32'(req_ready), 32'd1);
        check("rst_outs", 32'({done, fault, fault_cause, ren, wen, byte_select_vector}), 32'd0);
        check("rst_data", load_data | mem_wdata | 32'(data_addr), 32'd0);
        reset = 1'b0;
        step();

        run(1'b1, 3'b010, 32'h10, 32'hDEADBEEF, "sw10");
        run(1'b0, 3'b010, 32'h10, 32'h0, "lw10");
        run(1'b1, 3'b000, 32'h13, 32'h000000A5, "sb13");
        run(1'b0, 3'b000, 32'h13, 32'h0, "lb13");
        run(1'b0, 3'b100, 32'h13, 32'h0, "lbu13");
        run(1'b1, 3'b001, 32'h12, 32'h00008001, "sh12");
        run(1'b0, 3'b001, 32'h12, 32'h0, "lh12");
        run(1'b0, 3'b101, 32'h12, 32'h0, "lhu12");
        check("lh12_value", load_data, 32'h00008001);
        run(1'b0, 3'b010, 32'h11, 32'h0, "lw_mis");
        run(1'b0, 3'b011, 32'h10, 32'h0, "ld_f3_011");
        run(1'b1, 3'b100, 32'h10, 32'h0, "st_f3_100");
        run(1'b1, 3'b001, 32'h21, 32'h0, "sh_mis");

        for (int n = 0; n < 60; n++)
            run(1'(($urandom_range(0, 1))), 3'($urandom_range(0, 7)),
                32'($urandom_range(0, 255)), $urandom, $sformatf("rnd%0d", n));

        // Read that never sees mem_ready.
        stuck = 1'b1;
        req_valid = 1'b1; req_store = 1'b0; req_funct3 = 3'b010; req_addr = 32'h40;
        step();
        req_valid = 1'b0;
`ifdef LSU_TIMEOUT_EN
        k = 0; hits = 0;
        for (int i = 1; i <= 100; i++) begin
            step();
            if (done) hits++;
            if (fault) begin
                k = i;
                break;
            end
        end
        check("to_edge", 32'(k), 32'(TO + 2));
        check("to_cause", 32'(fault_cause), 32'd3);
        check("to_data", load_data, 32'd0);
        check("to_nodone", 32'(hits), 32'd0);
        step();
        check("to_pulse", 32'(fault), 32'd0);
        check("to_ready", 32'(req_ready), 32'd1);
        req_valid = 1'b1; req_addr = 32'h44;
        step();
        req_valid = 1'b0;
        for (int i = 0; i < 5; i++) step();
`else
        k = 0; hits = 0;
        for (int i = 0; i < 1000; i++) begin
            step();
            if (done || fault) hits++;
        end
        check("stall_no_complete", 32'(hits), 32'd0);
        check("stall_busy", 32'(req_ready), 32'd0);
`endif
        async_reset("rst_wait");
        run(1'b0, 3'b010, 32'h10, 32'h0, "lw_after_rst");

        // Reset while the read strobe is high.
        req_valid = 1'b1; req_store = 1'b0; req_funct3 = 3'b010; req_addr = 32'h20;
        step();
        req_valid = 1'b0;
        check("rst_ren_pre", 32'(ren), 32'd1);
        async_reset("rst_issue");
        run(1'b0, 3'b000, 32'h21, 32'h0, "lb_after_rst");
        run(1'b1, 3'b010, 32'h24, 32'h12345678, "sw_after_rst");
        run(1'b0, 3'b010, 32'h24, 32'h0, "lw_after_sw");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- CPU-side initiator for the data port of the unified instruction/data memory.
- Accepts one load or store per request from the execute stage, checks alignment, and builds the byte-select vector and store data lanes.
- Drives the memory ren/wen/ready handshake and returns sign- or zero-extended load data.
- Sits between the execute stage and the memory data port. Holds the pipeline through `req_ready` while a request is outstanding.

Parameters:
- MEM_AW, 10: width of the memory word address. 1024 words in synthesis.
- TIMEOUT_CYCLES, 64: read watchdog limit. Used only with the optional feature.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  LSU idle; request accepted on `req_valid & req_ready` at a rising edge
- req_store  in  1  1 = store, 0 = load
- req_funct3  in  3  RV32I funct3
- req_addr  in  32  byte address
- req_wdata  in  32  store data, right-aligned
- done  out  1  one-cycle completion pulse
- load_data  out  32  formatted load result; valid while `done` = 1 and held until the next load
- fault  out  1  one-cycle error pulse
- fault_cause  out  2  01 misaligned, 10 illegal funct3, 11 timeout
- data_addr  out  MEM_AW  word address, equal to `req_addr[MEM_AW+1:2]`
- ren  out  1  memory read strobe
- wen  out  1  memory write strobe
- mem_wdata  out  32  lane-aligned store data to memory
- byte_select_vector  out  4  write byte enables
- mem_rdata  in  32  memory read data
- mem_ready  in  1  memory ready

Behaviour:
- Reset values:
  - All outputs 0 except `req_ready` = 1.
  - State IDLE; watchdog counter 0.
  - A reset mid-operation abandons the access immediately; `ren`/`wen` drop asynchronously.
- All memory-side outputs, `done`, `fault` and `load_data` are registered.
- States: IDLE, ST_ISSUE, RD_ISSUE, RD_SKIP, RD_WAIT. `req_ready` = (state == IDLE).
- IDLE, on accept:
  - Illegal funct3 (load 011/110/111; store 1xx/011): pulse `fault`, cause 10, stay IDLE, no bus access.
  - Misaligned (H with `addr[0]`=1, W with `addr[1:0]`≠0): pulse `fault`, cause 01, stay IDLE, no bus access.
  - Otherwise latch the address, funct3 and `addr[1:0]`, then go to ST_ISSUE (store) or RD_ISSUE (load).
- ST_ISSUE:
  - `wen`=1, `ren`=0 for exactly one cycle.
  - SB: `byte_select_vector` = 0001<<`addr[1:0]`; `mem_wdata` = byte replicated ×4.
  - SH: `byte_select_vector` = 0011<<`addr[1:0]`; `mem_wdata` = half replicated ×2.
  - SW: `byte_select_vector` = 1111; `mem_wdata` = `req_wdata`.
  - Next: IDLE with `done`=1. Latency is 2 edges from accept to `done`.
- RD_ISSUE:
  - `ren`=1, `wen`=0 for exactly one cycle; `ren` never stays high longer, so the memory never re-triggers.
  - Next: RD_SKIP.
- RD_SKIP: ignore `mem_ready`, because the memory's ready drop is registered. Next: RD_WAIT.
- RD_WAIT:
  - When `mem_ready`=1, capture `mem_rdata` and format it:
    - Select byte or half by the latched `addr[1:0]`.
    - LB/LH sign-extend; LBU/LHU zero-extend; LW passes through.
  - Then `done`=1 and return to IDLE.
- An out-of-range address returns data 0 with ready never dropping. The LSU still completes normally, with `load_data` = 0.
- Back-to-back: a new request may be accepted in the same cycle `done` is high.
- `req_valid` while not ready is ignored, with no side effects.
- `done` and `fault` are never high together.

Optional Feature:
- LSU_TIMEOUT_EN defined: RD_WAIT counts cycles. On reaching TIMEOUT_CYCLES without `mem_ready`:
  - pulse `fault` with cause 11;
  - set `load_data` = 0;
  - no `done`;
  - return to IDLE.
- The counter clears on each entry to RD_WAIT.
- Undefined: RD_WAIT waits indefinitely; cause 11 never occurs; no counter is synthesised.

Decomposition:
- Shared include `constants.vh`:
  - funct3 codes (LB, LH, LW, LBU, LHU, SB, SH, SW);
  - LSU state encodings;
  - fault-cause codes.
- One sub-module, `lsu_load_align`: combinational extract/extend from `mem_rdata`, `addr[1:0]` and funct3 to a 32-bit result. It is instanced once, in front of the `load_data` register.

Test Plan:
- SW `addr`=0x10, `wdata`=0xDEADBEEF → `wen` for 1 cycle, `data_addr`=4, `byte_select_vector`=1111, `done` 2 edges after accept; then LW 0x10 → `ren` 1 cycle, `done` 9 edges after accept, `load_data`=0xDEADBEEF.
- SB `addr`=0x13, `wdata`=0x000000A5 → `byte_select_vector`=1000, `mem_wdata`=0xA5A5A5A5; then LB 0x13 → 0xFFFFFFA5; LBU 0x13 → 0x000000A5.
- LH `addr`=0x12 with word 0x8001xxxx → 0xFFFF8001; LHU → 0x00008001.
- LW `addr`=0x11 → `fault`, cause 01, same pulse timing as `done`, no `ren`/`wen` ever; LSU remains idle. funct3=011 load → cause 10.
- Reset asserted during RD_WAIT → `ren`/`wen`/`done` 0 immediately and `req_ready`=1. A following LW completes correctly.
- With LSU_TIMEOUT_EN, TIMEOUT_CYCLES=16, memory model holding `mem_ready`=0 → `fault` cause 11 exactly 16 cycles after RD_WAIT entry. Without the macro, still waiting after 1000 cycles.
